// File: rtl/tick_bcd_display_pkg.sv
// Shared constants for the tick-driven BCD display: segment patterns and digit count.
// Segment patterns are active-low, bit order {a,b,c,d,e,f,g}.
package tick_bcd_display_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [0:9][6:0] SEG_PAT = {
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100   // 9
   };

   typedef logic [3:0] bcd_t;

endpackage

// File: rtl/tick_bcd_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module bcd_to_seg7
   import tick_bcd_display_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      if (i_bcd <= 4'd9) o_seg = SEG_PAT[i_bcd];
   end

endmodule

// File: rtl/tick_bcd_display.sv
// Counts rising edges of a slow square wave as a 4-digit BCD value and scans it onto
// a multiplexed common-anode 7-segment display with a blinking colon.
module tick_bcd_display
   import tick_bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50_000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic slow_clk,
   input  logic run,
   input  logic up_down,
   input  logic clear,
   output logic dig3,
   output logic dig2,
   output logic dig1,
   output logic dig0,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g,
   output logic colon,
   output logic wrap
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic                         r_slow_q;
   logic [NUM_DIGITS-1:0][3:0]   r_count;
   logic [RW-1:0]                r_refresh_cnt;
   logic [1:0]                   r_scan_idx;
   logic [NUM_DIGITS-1:0]        r_dig;
   logic [6:0]                   r_seg;
   logic                         r_wrap;

   logic                         w_tick;
   logic [NUM_DIGITS-1:0][3:0]   w_count_inc;
   logic [NUM_DIGITS-1:0][3:0]   w_count_dec;
   logic                         w_carry;
   logic                         w_borrow;
   logic [NUM_DIGITS-1:0]        w_lz;
   logic                         w_blank;
   bcd_t                         w_digit;
   logic [6:0]                   w_seg;

   assign w_tick = slow_clk & ~r_slow_q;

   // Ripple carry/borrow through the digits; a surviving carry/borrow means full wrap.
   always_comb begin
      w_count_inc = r_count;
      w_count_dec = r_count;
      w_carry     = 1'b1;
      w_borrow    = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_carry) begin
            if (r_count[i] == 4'd9) begin
               w_count_inc[i] = 4'd0;
            end else begin
               w_count_inc[i] = r_count[i] + 4'd1;
               w_carry        = 1'b0;
            end
         end
         if (w_borrow) begin
            if (r_count[i] == 4'd0) begin
               w_count_dec[i] = 4'd9;
            end else begin
               w_count_dec[i] = r_count[i] - 4'd1;
               w_borrow       = 1'b0;
            end
         end
      end
   end

   // w_lz[i] is set when digit i and every digit above it are zero.
   always_comb begin
      w_lz = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (i == NUM_DIGITS - 1) w_lz[i] = (r_count[i] == 4'd0);
         else                     w_lz[i] = (r_count[i] == 4'd0) && w_lz[i+1];
      end
      w_blank = BLANK_LZ && (r_scan_idx != 2'd0) && w_lz[r_scan_idx];
   end

   assign w_digit = r_count[r_scan_idx];

   bcd_to_seg7 u_seg (
      .i_bcd (w_digit),
      .o_seg (w_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slow_q <= 1'b0;
         r_count  <= '0;
         r_wrap   <= 1'b0;
      end else begin
         r_slow_q <= slow_clk;
         r_wrap   <= 1'b0;
         if (clear) begin
            r_count <= '0;
         end else if (w_tick && run) begin
            if (up_down) begin
               r_count <= w_count_inc;
               r_wrap  <= w_carry;
            end else begin
               r_count <= w_count_dec;
               r_wrap  <= w_borrow;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refresh_cnt <= '0;
         r_scan_idx    <= 2'd0;
         r_dig         <= '1;
         r_seg         <= SEG_OFF;
      end else begin
         if (r_refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= r_scan_idx + 2'd1;
         end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
         end
         r_dig <= ~(NUM_DIGITS'(1) << r_scan_idx);
         r_seg <= w_blank ? SEG_OFF : w_seg;
      end
   end

   assign {dig3, dig2, dig1, dig0} = r_dig;
   assign {a, b, c, d, e, f, g}    = r_seg;
   assign colon                    = r_slow_q;
   assign wrap                     = r_wrap;

endmodule

// File: tb/tb_tick_bcd_display.sv
// Scoreboard bench for tick_bcd_display: each slow_clk edge pushes the expected count and
// wrap; a monitor pops on every colon rise and checks wrap plus one full display scan.
module tb_tick_bcd_display;

   localparam int RDIV = 4;

   logic clk = 1'b0;
   logic rst, slow_clk, run, up_down, clear;
   logic dig3, dig2, dig1, dig0;
   logic a, b, c, d, e, f, g;
   logic colon, wrap;

   int n_checks = 0;
   int n_errors = 0;
   int model_count = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic w;
      int   cnt;
   } exp_t;
   exp_t exp_q[$];

   tick_bcd_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .slow_clk(slow_clk), .run(run), .up_down(up_down), .clear(clear),
      .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .colon(colon), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] pat(input int v);
      case (v)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected pattern on digit position pos; leading zeros above digit 0 are blank.
   function automatic logic [6:0] exp_seg(input int cnt, input int pos);
      int scale;
      scale = 1;
      for (int k = 0; k < pos; k++) scale = scale * 10;
      if (pos > 0 && cnt < scale) return 7'b1111111;
      return pat((cnt / scale) % 10);
   endfunction

   task automatic do_tick(input logic r, input logic ud, input logic cl);
      exp_t x;
      @(negedge clk);
      run = r; up_down = ud; clear = cl; slow_clk = 1'b1;
      x.w = 1'b0;
      if (cl) begin
         model_count = 0;
      end else if (r && ud) begin
         x.w = (model_count == 9999);
         model_count = (model_count + 1) % 10000;
      end else if (r) begin
         x.w = (model_count == 0);
         model_count = (model_count + 9999) % 10000;
      end
      x.cnt = model_count;
      exp_q.push_back(x);
      @(negedge clk);
      clear = 1'b0;
      repeat (11) @(negedge clk);
      slow_clk = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   // colon mirrors slow_clk one clock late.
   always @(posedge clk) begin
      #1;
      if (mon_en) check("colon_lag", colon, slow_clk);
   end

   initial begin : monitor
      logic prev_colon;
      exp_t x;
      int   seen [4];
      int   bad_seg [4];
      int   bad_onehot;
      int   idx;
      prev_colon = 1'b0;
      wait (mon_en);
      forever begin
         @(posedge clk);
         #1;
         if (colon && !prev_colon) begin
            if (exp_q.size() == 0) begin
               check("unexpected_tick", 1, 0);
            end else begin
               x = exp_q.pop_front();
               check($sformatf("wrap@%0d", x.cnt), wrap, x.w);
               for (int i = 0; i < 4; i++) begin
                  seen[i] = 0;
                  bad_seg[i] = 0;
               end
               bad_onehot = 0;
               for (int s = 0; s < 16; s++) begin
                  @(posedge clk);
                  #1;
                  if (s == 0) check("wrap_one_cycle", wrap, 0);
                  case ({dig3, dig2, dig1, dig0})
                     4'b1110: idx = 0;
                     4'b1101: idx = 1;
                     4'b1011: idx = 2;
                     4'b0111: idx = 3;
                     default: idx = -1;
                  endcase
                  if (idx < 0) begin
                     bad_onehot++;
                  end else begin
                     seen[idx]++;
                     if ({a, b, c, d, e, f, g} !== exp_seg(x.cnt, idx)) bad_seg[idx]++;
                  end
               end
               check("dig_onehot", bad_onehot, 0);
               for (int i = 0; i < 4; i++) begin
                  check($sformatf("scan_dwell%0d", i), seen[i], RDIV);
                  check($sformatf("seg%0d@%0d", i, x.cnt), bad_seg[i], 0);
               end
            end
         end
         prev_colon = colon;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst = 1'b1; slow_clk = 1'b0; run = 1'b0; up_down = 1'b1; clear = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dig", {dig3, dig2, dig1, dig0}, 4'b1111);
      check("rst_seg", {a, b, c, d, e, f, g}, 7'b1111111);
      check("rst_colon", colon, 0);
      check("rst_wrap", wrap, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("first_refresh_dig", {dig3, dig2, dig1, dig0}, 4'b1110);
      check("first_refresh_seg", {a, b, c, d, e, f, g}, 7'b0000001);
      mon_en = 1'b1;

      // count up to 0012, then on to 0042
      for (int i = 0; i < 12; i++) do_tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) do_tick(1'b1, 1'b1, 1'b0);
      // clear coincident with a tick
      do_tick(1'b1, 1'b1, 1'b1);
      // 0000 -> 9999 (wrap) -> 9998, then up 9999 -> 0000 (wrap), down again -> 9999 (wrap)
      do_tick(1'b1, 1'b0, 1'b0);
      do_tick(1'b1, 1'b0, 1'b0);
      do_tick(1'b1, 1'b1, 1'b0);
      do_tick(1'b1, 1'b1, 1'b0);
      do_tick(1'b1, 1'b0, 1'b0);
      // hold while slow_clk keeps toggling
      for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1, 1'b0);

      // asynchronous reset in the middle of a cycle
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_dig", {dig3, dig2, dig1, dig0}, 4'b1111);
      check("midrst_seg", {a, b, c, d, e, f, g}, 7'b1111111);
      check("midrst_colon", colon, 0);
      @(negedge clk);
      rst = 1'b0;
      model_count = 0;
      do_tick(1'b1, 1'b1, 1'b0);

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
